attitude_estimation: RTL and testbench
======================================

ATTITUDE_ESTIMATION -- requirements
Module: attitude_estimation

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-003 SHALL have port SCLK, output, 1, shared SPI clock, mode 3 (idle high).
REQ-004 SHALL have port MOSI, output, 1, shared SPI data to sensors.
REQ-005 SHALL have port MISO_G, input, 1, gyro SPI data.
REQ-006 SHALL have port SS_G, output, 1, gyro select, active-low.
REQ-007 SHALL have port MISO_A, input, 1, accelerometer SPI data.
REQ-008 SHALL have port SS_A, output, 1, accelerometer select, active-low.
REQ-009 SHALL have ports gyro_x, gyro_y, accl_x, accl_y, accl_z, output, 16 each, signed two's-complement processed samples.

Function
REQ-010 SHALL generate SCLK = clk/2: bit period 2 clk; MOSI changes on SCLK falling edge; MISO sampled on SCLK rising edge.
REQ-011 SHALL run a free-running sequence after reset: GX, GY, AX, AY, AZ, then repeat forever.
REQ-012 SHALL insert 2 SCLK periods (4 clk) of idle between transactions: SS_G=SS_A=1, SCLK=1, MOSI=0.
REQ-013 SHALL never assert SS_G and SS_A simultaneously.
REQ-014 Gyro transaction SHALL be 24 bits: command byte MSB-first (0xE8 for X = read|auto-inc|0x28, 0xEA for Y), then 16 data bits with MOSI=0.
REQ-015 Gyro data SHALL arrive low byte then high byte, each MSB-first.
REQ-016 Accel transaction SHALL be 32 bits: command 0x0B, address byte (0x0E X, 0x10 Y, 0x12 Z), then 16 data bits with MOSI=0; MISO_A during first 16 bits is ignored.
REQ-017 Accel data SHALL arrive low byte then high byte, each MSB-first.
REQ-018 Raw value SHALL be {high byte, low byte}, interpreted signed.
REQ-019 Preprocessing SHALL saturate symmetric: raw -32768 becomes -32767; all other values pass unchanged.
REQ-020 The axis output SHALL update 1 clk after the final data bit is sampled and hold until that axis's next transaction completes; other outputs unaffected.
REQ-021 SHALL return SS high on the clk after the last SCLK rising edge of a transaction.
REQ-022 First transaction (GX) SHALL start with SS_G low 4 clk after reset deassertion.

Reset
REQ-023 While reset=0: SCLK=1, MOSI=0, SS_G=1, SS_A=1, all five data outputs 0, sequencer at GX idle state, shift registers cleared.
REQ-024 Reset asserted mid-transaction SHALL abort immediately; outputs keep no partial data; sequence restarts at GX.

Structure
REQ-025 Shared package SHALL hold: gyro/accel command bytes, register addresses, transaction bit counts (24, 32), idle length, axis enum (GX,GY,AX,AY,AZ).
REQ-026 One sub-module spi_xfer SHALL implement a generic N-bit mode-3 shift transaction (start, bit count, tx word, rx word, done); top holds sequencer FSM (IDLE, XFER, STORE) and preprocessing.

Verification
REQ-027 Reset: hold reset=0 10 clk -> SS_G=SS_A=1, SCLK=1, all outputs 0.
REQ-028 GX read: MISO_G supplies 0xFF then 0x7F in data phase -> gyro_x=32767; MOSI command bits = 0xE8.
REQ-029 Full cycle with all MISO data 0x7FFF (accel dummy bits driven 1) -> all five outputs 32767 after AZ completes; accel command 0x0B and addresses 0x0E/0x10/0x12 on MOSI.
REQ-030 Second cycle with data 0x8001 -> all outputs -32767; data 0x8000 on gyro_y -> gyro_y=-32767 (saturation).
REQ-031 Timing: measure SS_G low for exactly 48 clk, SS_A low 64 clk, 4 clk idle between; SS_G and SS_A never both low.
REQ-032 Reset mid-AX data phase -> SS_A high immediately, accl_x remains 0, next transaction is GX.

Source files
------------

// File: rtl/attitude_estimation_pkg.sv
// Shared constants, types and helpers for the attitude estimation sensor front end.
// Holds the sensor command bytes, transaction lengths, axis order and sequencer states.
package attitude_estimation_pkg;

  localparam logic [7:0] GYRO_CMD_X    = 8'hE8;
  localparam logic [7:0] GYRO_CMD_Y    = 8'hEA;
  localparam logic [7:0] ACCL_CMD_READ = 8'h0B;
  localparam logic [7:0] ACCL_ADDR_X   = 8'h0E;
  localparam logic [7:0] ACCL_ADDR_Y   = 8'h10;
  localparam logic [7:0] ACCL_ADDR_Z   = 8'h12;

  localparam logic [5:0] GYRO_XFER_BITS = 6'd24;
  localparam logic [5:0] ACCL_XFER_BITS = 6'd32;

  localparam int         IDLE_CLKS = 4;
  localparam logic [1:0] IDLE_LAST = 2'(IDLE_CLKS - 1);

  typedef enum logic [2:0] {GX, GY, AX, AY, AZ} axis_e;

  typedef enum logic [1:0] {IDLE, XFER, STORE} seq_state_e;

  function automatic axis_e next_axis(input axis_e axis);
    case (axis)
      GX:      return GY;
      GY:      return AX;
      AX:      return AY;
      AY:      return AZ;
      default: return GX;
    endcase
  endfunction

  // Left-aligned MOSI word; the data phase is always shifted out as zeros.
  function automatic logic [31:0] command_word(input axis_e axis);
    case (axis)
      GX:      return {GYRO_CMD_X, 24'h000000};
      GY:      return {GYRO_CMD_Y, 24'h000000};
      AX:      return {ACCL_CMD_READ, ACCL_ADDR_X, 16'h0000};
      AY:      return {ACCL_CMD_READ, ACCL_ADDR_Y, 16'h0000};
      AZ:      return {ACCL_CMD_READ, ACCL_ADDR_Z, 16'h0000};
      default: return 32'h0;
    endcase
  endfunction

  // Symmetric saturation keeps the range negatable: -32768 folds to -32767.
  function automatic logic [15:0] saturate_sym(input logic [15:0] raw);
    return (raw == 16'h8000) ? 16'h8001 : raw;
  endfunction

endpackage

// File: rtl/attitude_estimation_spi_xfer.sv
// Generic N-bit SPI mode-3 shift transaction (SCLK = clk/2, idle high).
// MOSI changes with SCLK falling, MISO is captured on the clk edge that raises SCLK.
module spi_xfer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  n_bits,
  input  logic [31:0] tx_word,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        busy,
  output logic [15:0] rx_word,
  output logic        done
);

  logic        busy_q, busy_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [5:0]  n_bits_q, n_bits_d;
  logic [31:0] tx_shift_q, tx_shift_d;
  logic [15:0] rx_shift_q, rx_shift_d;
  logic [6:0]  last_cnt;

  // cnt_q counts half bit periods; even = SCLK low, odd = SCLK high.
  assign last_cnt = {n_bits_q - 6'd1, 1'b1};
  assign done     = busy_q && (cnt_q == last_cnt);

  always_comb begin
    busy_d     = busy_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cnt_d      = cnt_q;
    n_bits_d   = n_bits_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    if (!busy_q) begin
      if (start) begin
        busy_d     = 1'b1;
        sclk_d     = 1'b0;
        mosi_d     = tx_word[31];
        tx_shift_d = {tx_word[30:0], 1'b0};
        cnt_d      = 7'd0;
        n_bits_d   = n_bits;
        rx_shift_d = 16'h0000;
      end
    end else if (!cnt_q[0]) begin
      sclk_d     = 1'b1;
      rx_shift_d = {rx_shift_q[14:0], miso};
      cnt_d      = cnt_q + 7'd1;
    end else if (done) begin
      busy_d = 1'b0;
      sclk_d = 1'b1;
      mosi_d = 1'b0;
      cnt_d  = 7'd0;
    end else begin
      sclk_d     = 1'b0;
      mosi_d     = tx_shift_q[31];
      tx_shift_d = {tx_shift_q[30:0], 1'b0};
      cnt_d      = cnt_q + 7'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      sclk_q     <= 1'b1;
      mosi_q     <= 1'b0;
      cnt_q      <= 7'd0;
      n_bits_q   <= 6'd0;
      tx_shift_q <= 32'h0;
      rx_shift_q <= 16'h0000;
    end else begin
      busy_q     <= busy_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cnt_q      <= cnt_d;
      n_bits_q   <= n_bits_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign busy    = busy_q;
  assign rx_word = rx_shift_q;

endmodule

// File: rtl/attitude_estimation.sv
// Free-running gyro/accelerometer reader: polls GX, GY, AX, AY, AZ over a shared SPI bus
// and publishes each axis as a symmetrically saturated signed 16-bit sample.
module attitude_estimation
  import attitude_estimation_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO_G,
  output logic        SS_G,
  input  logic        MISO_A,
  output logic        SS_A,
  output logic [15:0] gyro_x,
  output logic [15:0] gyro_y,
  output logic [15:0] accl_x,
  output logic [15:0] accl_y,
  output logic [15:0] accl_z
);

  seq_state_e  state_q, state_d;
  axis_e       axis_q, axis_d;
  logic [1:0]  idle_cnt_q, idle_cnt_d;
  logic [15:0] gyro_x_q, gyro_x_d;
  logic [15:0] gyro_y_q, gyro_y_d;
  logic [15:0] accl_x_q, accl_x_d;
  logic [15:0] accl_y_q, accl_y_d;
  logic [15:0] accl_z_q, accl_z_d;

  logic        is_gyro;
  logic        xfer_start;
  logic        xfer_busy;
  logic        xfer_done;
  logic        spi_miso;
  logic [5:0]  xfer_bits;
  logic [31:0] xfer_tx;
  logic [15:0] xfer_rx;
  logic [15:0] sample;

  assign is_gyro   = (axis_q == GX) || (axis_q == GY);
  assign xfer_bits = is_gyro ? GYRO_XFER_BITS : ACCL_XFER_BITS;
  assign xfer_tx   = command_word(axis_q);
  assign spi_miso  = is_gyro ? MISO_G : MISO_A;
  // Both sensors send the low byte first, so the byte halves are swapped here.
  assign sample    = saturate_sym({xfer_rx[7:0], xfer_rx[15:8]});

  spi_xfer u_spi_xfer (
    .clk     (clk),
    .rst_n   (reset),
    .start   (xfer_start),
    .n_bits  (xfer_bits),
    .tx_word (xfer_tx),
    .miso    (spi_miso),
    .sclk    (SCLK),
    .mosi    (MOSI),
    .busy    (xfer_busy),
    .rx_word (xfer_rx),
    .done    (xfer_done)
  );

  always_comb begin
    state_d    = state_q;
    axis_d     = axis_q;
    idle_cnt_d = idle_cnt_q;
    gyro_x_d   = gyro_x_q;
    gyro_y_d   = gyro_y_q;
    accl_x_d   = accl_x_q;
    accl_y_d   = accl_y_q;
    accl_z_d   = accl_z_q;
    xfer_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (idle_cnt_q == IDLE_LAST) begin
          xfer_start = 1'b1;
          idle_cnt_d = 2'd0;
          state_d    = XFER;
        end else begin
          idle_cnt_d = idle_cnt_q + 2'd1;
        end
      end
      XFER: begin
        if (xfer_done) begin
          state_d = STORE;
          case (axis_q)
            GX:      gyro_x_d = sample;
            GY:      gyro_y_d = sample;
            AX:      accl_x_d = sample;
            AY:      accl_y_d = sample;
            default: accl_z_d = sample;
          endcase
        end
      end
      STORE: begin
        // STORE is already the first idle clock of the inter-transaction gap.
        axis_d     = next_axis(axis_q);
        idle_cnt_d = 2'd1;
        state_d    = IDLE;
      end
      default: begin
        state_d    = IDLE;
        idle_cnt_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      axis_q     <= GX;
      idle_cnt_q <= 2'd0;
      gyro_x_q   <= 16'h0000;
      gyro_y_q   <= 16'h0000;
      accl_x_q   <= 16'h0000;
      accl_y_q   <= 16'h0000;
      accl_z_q   <= 16'h0000;
    end else begin
      state_q    <= state_d;
      axis_q     <= axis_d;
      idle_cnt_q <= idle_cnt_d;
      gyro_x_q   <= gyro_x_d;
      gyro_y_q   <= gyro_y_d;
      accl_x_q   <= accl_x_d;
      accl_y_q   <= accl_y_d;
      accl_z_q   <= accl_z_d;
    end
  end

  assign SS_G   = ~(xfer_busy & is_gyro);
  assign SS_A   = ~(xfer_busy & ~is_gyro);
  assign gyro_x = gyro_x_q;
  assign gyro_y = gyro_y_q;
  assign accl_x = accl_x_q;
  assign accl_y = accl_y_q;
  assign accl_z = accl_z_q;

endmodule

// File: tb/tb_attitude_estimation.sv
// Self-checking bench for attitude_estimation: behavioural gyro/accel SPI slaves that decode
// the commands they receive, a transaction monitor, table-driven and randomized polling cycles.
module tb_attitude_estimation;

  logic        clk = 1'b0;
  logic        reset;
  logic        SCLK, MOSI, SS_G, SS_A;
  logic        MISO_G, MISO_A;
  logic [15:0] gyro_x, gyro_y, accl_x, accl_y, accl_z;

  int n_compared   = 0;
  int n_mismatched = 0;

  attitude_estimation dut (
    .clk    (clk),
    .reset  (reset),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .MISO_G (MISO_G),
    .SS_G   (SS_G),
    .MISO_A (MISO_A),
    .SS_A   (SS_A),
    .gyro_x (gyro_x),
    .gyro_y (gyro_y),
    .accl_x (accl_x),
    .accl_y (accl_y),
    .accl_z (accl_z)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0][15:0] raw;
    logic [4:0][15:0] expv;
  } vec_t;

  // Sensor register contents (index 0..4 = GX, GY, AX, AY, AZ) and the expected outputs.
  logic [15:0] sens_reg [5];
  logic [15:0] exp_out  [5];

  int          cycles_done = 0;
  int          xfers_done  = 0;
  int          seq_idx     = 0;
  int          g_bit, a_bit, g_low, a_low, idle_len, idle_bad, overlap;
  logic [31:0] g_frame, a_frame;
  logic [7:0]  g_cmd, a_addr;
  bit          seen_first;
  logic        ss_g_prev, ss_a_prev;

  // Reference preprocessing: clamp the signed reading into [-32767, 32767].
  function automatic logic [15:0] model_sat(input logic [15:0] raw);
    int v;
    v = int'($signed(raw));
    if (v < -32767) v = -32767;
    if (v > 32767) v = 32767;
    return 16'(v);
  endfunction

  // Sensor wire order: low byte MSB-first, then high byte MSB-first.
  function automatic logic serial_bit(input logic [15:0] w, input int j);
    logic [15:0] stream;
    stream = {w[7:0], w[15:8]};
    return stream[15-j];
  endfunction

  function automatic logic [15:0] gyro_word(input logic [7:0] cmd);
    case (cmd)
      8'hE8:   return sens_reg[0];
      8'hEA:   return sens_reg[1];
      default: return 16'hDEAD;
    endcase
  endfunction

  function automatic logic [15:0] accel_word(input logic [7:0] addr);
    case (addr)
      8'h0E:   return sens_reg[2];
      8'h10:   return sens_reg[3];
      8'h12:   return sens_reg[4];
      default: return 16'hDEAD;
    endcase
  endfunction

  function automatic logic [31:0] exp_frame(input int k);
    case (k)
      0:       return 32'h00E80000;
      1:       return 32'h00EA0000;
      2:       return 32'h0B0E0000;
      3:       return 32'h0B100000;
      default: return 32'h0B120000;
    endcase
  endfunction

  function automatic string axis_name(input int k);
    case (k)
      0:       return "gyro_x";
      1:       return "gyro_y";
      2:       return "accl_x";
      3:       return "accl_y";
      default: return "accl_z";
    endcase
  endfunction

  function automatic logic [15:0] dut_out(input int k);
    case (k)
      0:       return gyro_x;
      1:       return gyro_y;
      2:       return accl_x;
      3:       return accl_y;
      default: return accl_z;
    endcase
  endfunction

  function automatic vec_t mk(input logic [15:0] gx, gy, ax, ay, az,
                              input logic [15:0] egx, egy, eax, eay, eaz);
    vec_t v;
    v.raw[0] = gx;   v.raw[1] = gy;   v.raw[2] = ax;   v.raw[3] = ay;   v.raw[4] = az;
    v.expv[0] = egx; v.expv[1] = egy; v.expv[2] = eax; v.expv[3] = eay; v.expv[4] = eaz;
    return v;
  endfunction

  function automatic logic [15:0] rand_raw();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h8001;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    for (int k = 0; k < 5; k++) sens_reg[k] = v.raw[k];
  endtask

  task automatic checkOutput(input vec_t v, input string label);
    for (int k = 0; k < 5; k++)
      checkValue($sformatf("%s_%s", label, axis_name(k)), dut_out(k), v.expv[k]);
  endtask

  task automatic finishXfer(input int low, input int bits, input logic [31:0] frame,
                            input int exp_low, input int exp_bits);
    checkValue($sformatf("ss_low_clk_%s", axis_name(seq_idx)), low, exp_low);
    checkValue($sformatf("frame_bits_%s", axis_name(seq_idx)), bits, exp_bits);
    checkValue($sformatf("mosi_frame_%s", axis_name(seq_idx)), frame, exp_frame(seq_idx));
    checkValue("ss_no_overlap", overlap, 0);
    exp_out[seq_idx] = model_sat(sens_reg[seq_idx]);
    for (int k = 0; k < 5; k++)
      checkValue($sformatf("xfer_out_%s", axis_name(k)), dut_out(k), exp_out[k]);
    if (seq_idx == 4) cycles_done++;
    seq_idx    = (seq_idx + 1) % 5;
    xfers_done++;
    idle_len   = 0;
    seen_first = 1'b1;
  endtask

  // Sensor models and bus monitor, evaluated mid-cycle away from the active clock edge.
  always @(negedge clk) begin
    if (!reset) begin
      g_bit = 0; a_bit = 0; g_low = 0; a_low = 0;
      idle_len = 0; idle_bad = 0; overlap = 0;
      g_frame = 32'h0; a_frame = 32'h0; g_cmd = 8'h00; a_addr = 8'h00;
      seen_first = 1'b0; ss_g_prev = 1'b1; ss_a_prev = 1'b1; seq_idx = 0;
      MISO_G = 1'b1; MISO_A = 1'b1;
      for (int k = 0; k < 5; k++) exp_out[k] = 16'h0000;
    end else begin
      if (!SS_G && !SS_A) overlap++;
      if ((!SS_G && ss_g_prev) || (!SS_A && ss_a_prev)) begin
        if (seen_first) checkValue("idle_len", idle_len, 4);
        checkValue("idle_lines", idle_bad, 0);
        checkValue("select_dev", {31'd0, !SS_G}, (seq_idx < 2) ? 32'd1 : 32'd0);
        g_bit = 0; a_bit = 0; g_low = 0; a_low = 0; idle_bad = 0;
        g_frame = 32'h0; a_frame = 32'h0; g_cmd = 8'h00; a_addr = 8'h00;
      end
      if (!SS_G) begin
        g_low++;
        if (!SCLK) MISO_G = (g_bit < 8) ? 1'b1 : serial_bit(gyro_word(g_cmd), g_bit - 8);
        else begin
          g_frame = {g_frame[30:0], MOSI};
          if (g_bit < 8) g_cmd = {g_cmd[6:0], MOSI};
          g_bit++;
        end
      end
      if (!SS_A) begin
        a_low++;
        if (!SCLK) MISO_A = (a_bit < 16) ? 1'b1 : serial_bit(accel_word(a_addr), a_bit - 16);
        else begin
          a_frame = {a_frame[30:0], MOSI};
          if (a_bit >= 8 && a_bit < 16) a_addr = {a_addr[6:0], MOSI};
          a_bit++;
        end
      end
      if (SS_G && !ss_g_prev) finishXfer(g_low, g_bit, g_frame, 48, 24);
      if (SS_A && !ss_a_prev) finishXfer(a_low, a_bit, a_frame, 64, 32);
      if (SS_G && SS_A) begin
        idle_len++;
        if (MOSI !== 1'b0 || SCLK !== 1'b1) idle_bad++;
      end
      ss_g_prev = SS_G;
      ss_a_prev = SS_A;
    end
  end

  task automatic waitForCycles(input int target);
    int n = 0;
    while (cycles_done < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkValue("cycle_complete", (cycles_done >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic countToSelect(output int n);
    n = 0;
    while (SS_G !== 1'b0 && SS_A !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t all_v[$];
    int   base, n;

    all_v.push_back(mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                       16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF));
    all_v.push_back(mk(16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h8001,
                       16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h8001));
    all_v.push_back(mk(16'h1234, 16'h8000, 16'h0000, 16'hFFFF, 16'h4321,
                       16'h1234, 16'h8001, 16'h0000, 16'hFFFF, 16'h4321));
    all_v.push_back(mk(16'h8000, 16'h00AB, 16'hAB00, 16'h8000, 16'h8000,
                       16'h8001, 16'h00AB, 16'hAB00, 16'h8001, 16'h8001));
    all_v.push_back(mk(16'hFF00, 16'h0102, 16'h7FFE, 16'h8002, 16'h00FF,
                       16'hFF00, 16'h0102, 16'h7FFE, 16'h8002, 16'h00FF));
    for (int r = 0; r < 16; r++) begin
      logic [15:0] gx, gy, ax, ay, az;
      gx = rand_raw(); gy = rand_raw(); ax = rand_raw(); ay = rand_raw(); az = rand_raw();
      all_v.push_back(mk(gx, gy, ax, ay, az, model_sat(gx), model_sat(gy), model_sat(ax),
                         model_sat(ay), model_sat(az)));
    end

    reset = 1'b0;
    applyStimulus(all_v[0]);
    repeat (10) @(negedge clk);
    checkValue("reset_ss_g", SS_G, 1);
    checkValue("reset_ss_a", SS_A, 1);
    checkValue("reset_sclk", SCLK, 1);
    checkValue("reset_mosi", MOSI, 0);
    for (int k = 0; k < 5; k++)
      checkValue($sformatf("reset_%s", axis_name(k)), dut_out(k), 16'h0000);

    reset = 1'b1;
    countToSelect(n);
    checkValue("first_select_delay", n, 4);
    checkValue("first_is_gyro", {SS_G, SS_A}, 2'b01);

    base = cycles_done;
    for (int i = 0; i < all_v.size(); i++) begin
      waitForCycles(base + i + 1);
      checkOutput(all_v[i], (i < 5) ? $sformatf("tbl%0d", i) : $sformatf("rnd%0d", i));
      if (i + 1 < all_v.size()) applyStimulus(all_v[i + 1]);
    end

    // Abort in the middle of the AX data phase.
    applyStimulus(mk(16'h1357, 16'h2468, 16'h7ABC, 16'h0BCD, 16'h0F0F,
                     16'h0, 16'h0, 16'h0, 16'h0, 16'h0));
    n = 0;
    while (!(seq_idx == 2 && SS_A === 1'b0 && a_bit >= 20) && n < 600) begin
      @(negedge clk);
      n++;
    end
    checkValue("reach_ax_data", (seq_idx == 2 && a_bit >= 20) ? 32'd1 : 32'd0, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkValue("abort_ss_a", SS_A, 1);
    checkValue("abort_ss_g", SS_G, 1);
    checkValue("abort_sclk", SCLK, 1);
    checkValue("abort_accl_x", accl_x, 16'h0000);
    checkValue("abort_gyro_x", gyro_x, 16'h0000);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    countToSelect(n);
    checkValue("restart_delay", n, 4);
    checkValue("restart_is_gyro", {SS_G, SS_A}, 2'b01);
    base = xfers_done;
    n = 0;
    while (xfers_done == base && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkValue("restart_gx_done", (xfers_done > base) ? 32'd1 : 32'd0, 32'd1);
    checkValue("restart_gyro_x", gyro_x, model_sat(16'h1357));
    checkValue("restart_accl_x", accl_x, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
